// File: rtl/cordic_lin_pkg.sv
// Shared types and helpers for the linear-mode CORDIC unit.
// Holds the FSM state enum, operation mode enum and internal datapath width.
package cordic_lin_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

    typedef enum logic {
        VECT = 1'b0,
        ROT  = 1'b1
    } mode_e;

    // The y/z datapath carries guard MSBs above the I/O width.
    function automatic int unsigned int_width(input int unsigned io_width,
                                              input int unsigned guard_bits);
        return io_width + guard_bits;
    endfunction

endpackage

// File: rtl/cordic_lin_step.sv
// One combinational linear-CORDIC micro-rotation (vectoring divides, rotation multiplies).
// x is never modified; y and z move by x>>>k and 2^-k in the direction picked by d.
module cordic_lin_step
    import cordic_lin_pkg::*;
#(
    parameter int unsigned INT_WIDTH = 20,
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned K_WIDTH   = 5
) (
    input  logic signed [INT_WIDTH-1:0] x_i,
    input  logic signed [INT_WIDTH-1:0] y_i,
    input  logic signed [INT_WIDTH-1:0] z_i,
    input  logic        [K_WIDTH-1:0]   k_i,
    input  mode_e                       mode_i,
    output logic signed [INT_WIDTH-1:0] y_o,
    output logic signed [INT_WIDTH-1:0] z_o
);

    logic signed [INT_WIDTH-1:0] x_sh;
    logic signed [INT_WIDTH-1:0] z_step;
    logic                        d_pos;

    always_comb begin
        x_sh   = x_i >>> k_i;
        // 2^-k expressed in the z fixed-point format
        z_step = INT_WIDTH'(1) << (K_WIDTH'(FRAC_BITS) - k_i);
        d_pos  = 1'b0;
        y_o    = y_i;
        z_o    = z_i;
        if (mode_i == VECT) begin
            d_pos = (y_i[INT_WIDTH-1] == x_i[INT_WIDTH-1]);
            y_o   = d_pos ? (y_i - x_sh)   : (y_i + x_sh);
            z_o   = d_pos ? (z_i + z_step) : (z_i - z_step);
        end else begin
            d_pos = !z_i[INT_WIDTH-1];
            y_o   = d_pos ? (y_i + x_sh)   : (y_i - x_sh);
            z_o   = d_pos ? (z_i - z_step) : (z_i + z_step);
        end
    end

endmodule

// File: rtl/cordic_lin_unit.sv
// Iterative linear CORDIC: vectoring (z = z0 + y/x) or rotation (y = y0 + x*z0).
// Define CORDIC_LIN_SAT_EN to saturate y_o/z_o and report ovf_o; otherwise results wrap.
module cordic_lin_unit
    import cordic_lin_pkg::*;
#(
    parameter int unsigned IO_WIDTH   = 18,
    parameter int unsigned FRAC_BITS  = 15,
    parameter int unsigned ITER_NUM   = 16,
    parameter int unsigned GUARD_BITS = 2
) (
    input  logic                       sys_clk_i,
    input  logic                       reset_n_i,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic signed [IO_WIDTH-1:0] x_i,
    input  logic signed [IO_WIDTH-1:0] y_i,
    input  logic signed [IO_WIDTH-1:0] z_i,
    output logic                       ready_o,
    output logic                       done_o,
    output logic signed [IO_WIDTH-1:0] x_o,
    output logic signed [IO_WIDTH-1:0] y_o,
    output logic signed [IO_WIDTH-1:0] z_o,
    output logic                       err_o,
    output logic                       ovf_o
);

    localparam int unsigned IntW = int_width(IO_WIDTH, GUARD_BITS);
    localparam int unsigned KW   = $clog2(FRAC_BITS + 2);

    state_e                  state_q, state_d;
    logic        [KW-1:0]    k_q, k_d;
    mode_e                   mode_q, mode_d;
    logic signed [IntW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic                    xz_q, xz_d;
    logic signed [IO_WIDTH-1:0] x_res_q, x_res_d, y_res_q, y_res_d, z_res_q, z_res_d;
    logic                    err_q, err_d, ovf_q, ovf_d;

    logic signed [IntW-1:0]     step_y, step_z;
    logic signed [IO_WIDTH-1:0] y_red, z_red;
    logic                       ovf_red;

    cordic_lin_step #(
        .INT_WIDTH (IntW),
        .FRAC_BITS (FRAC_BITS),
        .K_WIDTH   (KW)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .k_i    (k_q),
        .mode_i (mode_q),
        .y_o    (step_y),
        .z_o    (step_z)
    );

`ifdef CORDIC_LIN_SAT_EN
    localparam logic signed [IO_WIDTH-1:0] SatMax = {1'b0, {(IO_WIDTH-1){1'b1}}};
    localparam logic signed [IO_WIDTH-1:0] SatMin = {1'b1, {(IO_WIDTH-1){1'b0}}};

    logic signed [IntW-1:0] y_fin, z_fin;
    logic                   y_ovf, z_ovf;

    always_comb begin
        // x=0 vectoring keeps the operands untouched
        y_fin   = xz_q ? y_q : step_y;
        z_fin   = xz_q ? z_q : step_z;
        y_ovf   = (y_fin[IntW-1:IO_WIDTH-1] != {(GUARD_BITS+1){y_fin[IntW-1]}});
        z_ovf   = (z_fin[IntW-1:IO_WIDTH-1] != {(GUARD_BITS+1){z_fin[IntW-1]}});
        y_red   = y_ovf ? (y_fin[IntW-1] ? SatMin : SatMax) : y_fin[IO_WIDTH-1:0];
        z_red   = z_ovf ? (z_fin[IntW-1] ? SatMin : SatMax) : z_fin[IO_WIDTH-1:0];
        ovf_red = y_ovf | z_ovf;
    end
`else
    always_comb begin
        y_red   = xz_q ? y_q[IO_WIDTH-1:0] : step_y[IO_WIDTH-1:0];
        z_red   = xz_q ? z_q[IO_WIDTH-1:0] : step_z[IO_WIDTH-1:0];
        ovf_red = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xz_d    = xz_q;
        x_res_d = x_res_q;
        y_res_d = y_res_q;
        z_res_d = z_res_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StIter;
                    k_d     = '0;
                    mode_d  = mode_e'(mode_i);
                    x_d     = {{GUARD_BITS{x_i[IO_WIDTH-1]}}, x_i};
                    y_d     = {{GUARD_BITS{y_i[IO_WIDTH-1]}}, y_i};
                    z_d     = {{GUARD_BITS{z_i[IO_WIDTH-1]}}, z_i};
                    xz_d    = (mode_i == VECT) && (x_i == '0);
                end
            end
            StIter: begin
                if (!xz_q) begin
                    y_d = step_y;
                    z_d = step_z;
                end
                k_d = k_q + KW'(1);
                if (k_q == KW'(ITER_NUM - 1)) begin
                    state_d = StDone;
                    x_res_d = x_q[IO_WIDTH-1:0];
                    y_res_d = y_red;
                    z_res_d = z_red;
                    err_d   = xz_q;
                    ovf_d   = ovf_red;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            k_q     <= '0;
            mode_q  <= VECT;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xz_q    <= 1'b0;
            x_res_q <= '0;
            y_res_q <= '0;
            z_res_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xz_q    <= xz_d;
            x_res_q <= x_res_d;
            y_res_q <= y_res_d;
            z_res_q <= z_res_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o = (state_q == StIdle);
    assign done_o  = (state_q == StDone);
    assign x_o     = x_res_q;
    assign y_o     = y_res_q;
    assign z_o     = z_res_q;
    assign err_o   = err_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_cordic_lin_unit.sv
// Directed self-checking bench for cordic_lin_unit (default parameters, 1.0 = 32768).
// Expectations for the overflow vector follow CORDIC_LIN_SAT_EN.
module tb_cordic_lin_unit;

    logic               sys_clk;
    logic               reset_n;
    logic               start;
    logic               mode;
    logic signed [17:0] x_in, y_in, z_in;
    logic               ready, done, err, ovf;
    logic signed [17:0] x_out, y_out, z_out;

    int checks;
    int failures;

    cordic_lin_unit dut (
        .sys_clk_i (sys_clk),
        .reset_n_i (reset_n),
        .start_i   (start),
        .mode_i    (mode),
        .x_i       (x_in),
        .y_i       (y_in),
        .z_i       (z_in),
        .ready_o   (ready),
        .done_o    (done),
        .x_o       (x_out),
        .y_o       (y_out),
        .z_o       (z_out),
        .err_o     (err),
        .ovf_o     (ovf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Drive one request, then count cycles (1 = cycle after accept edge) until done.
    task automatic run_op(input logic m, input int xv, input int yv, input int zv,
                          output int lat);
        @(negedge sys_clk);
        mode  = m;
        x_in  = 18'(xv);
        y_in  = 18'(yv);
        z_in  = 18'(zv);
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge sys_clk);
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b1;
        mode    = 1'b1;
        x_in    = 18'sd100;
        y_in    = 18'sd100;
        z_in    = 18'sd100;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 1", ready);
        end
        checks++;
        if ({done, err, ovf} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {done, err, ovf});
        end
        checks++;
        if ({x_out, y_out, z_out} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0d/%0d/%0d expected 0/0/0", x_out, y_out, z_out);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_vectoring;
        int lat;
        run_op(1'b0, 16384, 8192, 0, lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL vect_latency: got %0d expected 17", lat);
        end
        checks++;
        if (z_out < 16382 || z_out > 16386) begin
            failures++;
            $display("FAIL vect_z: got %0d expected 16384+/-2", z_out);
        end
        checks++;
        if (y_out < -2 || y_out > 2) begin
            failures++;
            $display("FAIL vect_y: got %0d expected |y|<=2", y_out);
        end
        checks++;
        if ({err, ovf} !== 2'b00 || x_out !== 18'sd16384) begin
            failures++;
            $display("FAIL vect_flags_x: got err=%b ovf=%b x=%0d expected 0 0 16384",
                     err, ovf, x_out);
        end
    endtask

    task automatic test_rotation;
        int lat;
        run_op(1'b1, 16384, 8192, 16384, lat);
        checks++;
        if (y_out < 16382 || y_out > 16386) begin
            failures++;
            $display("FAIL rot_y: got %0d expected 16384+/-2", y_out);
        end
        checks++;
        if (x_out !== 18'sd16384) begin
            failures++;
            $display("FAIL rot_x: got %0d expected 16384", x_out);
        end
        run_op(1'b1, 32768, 0, -8192, lat);
        checks++;
        if (y_out < -8194 || y_out > -8190) begin
            failures++;
            $display("FAIL rot_neg_y: got %0d expected -8192+/-2", y_out);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL rot_latency: got %0d expected 17", lat);
        end
    endtask

    task automatic test_x_zero;
        int lat;
        run_op(1'b0, 0, 1000, 5, lat);
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL xzero_latency: got %0d expected 17", lat);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL xzero_err: got %b expected 1", err);
        end
        checks++;
        if (z_out !== 18'sd5 || y_out !== 18'sd1000) begin
            failures++;
            $display("FAIL xzero_yz: got y=%0d z=%0d expected y=1000 z=5", y_out, z_out);
        end
    endtask

    task automatic test_ignore_start;
        int ready_bad;
        int dones;
        int done_at;
        logic signed [17:0] z_save;
        ready_bad = 0;
        dones     = 0;
        done_at   = 0;
        z_save    = '0;
        @(negedge sys_clk);
        mode  = 1'b0;
        x_in  = 18'sd16384;
        y_in  = 18'sd8192;
        z_in  = 18'sd0;
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge sys_clk);
            if (c <= 17 && ready !== 1'b0) ready_bad++;
            if (done === 1'b1) begin
                dones++;
                if (done_at == 0) begin
                    done_at = c;
                    z_save  = z_out;
                end
            end
            if (c == 3 || c == 10) begin
                mode  = 1'b1;
                x_in  = 18'sd1000;
                y_in  = -18'sd3000;
                z_in  = 18'sd20000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (ready_bad !== 0) begin
            failures++;
            $display("FAIL busy_ready: got %0d high cycles expected 0", ready_bad);
        end
        checks++;
        if (dones !== 1 || done_at !== 17) begin
            failures++;
            $display("FAIL busy_done: got %0d pulses at %0d expected 1 at 17", dones, done_at);
        end
        checks++;
        if (z_save < 16382 || z_save > 16386) begin
            failures++;
            $display("FAIL busy_result: got %0d expected 16384+/-2", z_save);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int dones;
        dones = 0;
        @(negedge sys_clk);
        mode  = 1'b1;
        x_in  = 18'sd16384;
        y_in  = 18'sd8192;
        z_in  = 18'sd16384;
        start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge sys_clk);
            if (done === 1'b1) dones++;
        end
        reset_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got ready=%b done=%b expected 1 0", ready, done);
        end
        checks++;
        if ({x_out, y_out, z_out, err, ovf} !== 56'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %0d/%0d/%0d err=%b ovf=%b expected all 0",
                     x_out, y_out, z_out, err, ovf);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge sys_clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", dones);
        end
        run_op(1'b1, 16384, 8192, 16384, lat);
        checks++;
        if (lat !== 17 || y_out < 16382 || y_out > 16386) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d y=%0d expected 17 16384+/-2", lat, y_out);
        end
    endtask

    task automatic test_saturation;
        int lat;
        run_op(1'b1, 114688, 114688, 62000, lat);
`ifdef CORDIC_LIN_SAT_EN
        checks++;
        if (y_out !== 18'sd131071 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_y: got y=%0d ovf=%b expected 131071 1", y_out, ovf);
        end
`else
        // Internal value is about 331688; its low 18 bits are about 69544.
        checks++;
        if (y_out < 69536 || y_out > 69552 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL wrap_y: got y=%0d ovf=%b expected 69544+/-8 0", y_out, ovf);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int d1;
        int d2;
        int c;
        logic signed [17:0] y2;
        d1 = 0;
        d2 = 0;
        c  = 0;
        y2 = '0;
        @(negedge sys_clk);
        mode  = 1'b1;
        x_in  = 18'sd32768;
        y_in  = 18'sd0;
        z_in  = -18'sd8192;
        start = 1'b1;
        while (c < 60 && d2 == 0) begin
            @(negedge sys_clk);
            c++;
            if (done === 1'b1) begin
                if (d1 == 0) d1 = c;
                else begin
                    d2 = c;
                    y2 = y_out;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (d1 === 0 || d2 === 0 || (d2 - d1) !== 18) begin
            failures++;
            $display("FAIL b2b_period: got done at %0d and %0d expected 18 apart", d1, d2);
        end
        checks++;
        if (y2 < -8194 || y2 > -8190) begin
            failures++;
            $display("FAIL b2b_result: got %0d expected -8192+/-2", y2);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (ready === 1'b1) break;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        x_in     = '0;
        y_in     = '0;
        z_in     = '0;
        test_reset();
        test_vectoring();
        test_rotation();
        test_x_zero();
        test_ignore_start();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cordic_lin_unit.md
CORDIC_LIN_UNIT -- requirements
Module: cordic_lin_unit

Interface
REQ-001 Parameter IO_WIDTH, 18: width of all data ports, signed two's complement.
REQ-002 Parameter FRAC_BITS, 15: fraction bits of every data port (Q(IO_WIDTH-FRAC_BITS).FRAC_BITS).
REQ-003 Parameter ITER_NUM, 16: micro-rotations per operation; legal range 2..FRAC_BITS+1.
REQ-004 Parameter GUARD_BITS, 2: extra MSBs on the internal y/z datapath.
REQ-005 sys_clk_i  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_n_i  in  1  synchronous, active-low reset.
REQ-007 start_i  in  1  request; accepted only when ready_o=1.
REQ-008 mode_i  in  1  0 = vectoring (divide, z = z0 + y/x), 1 = rotation (multiply-add, y = y0 + x*z0); sampled on accept.
REQ-009 x_i, y_i, z_i  in  IO_WIDTH each  operands; sampled on accept.
REQ-010 ready_o  out  1  high in IDLE only.
REQ-011 done_o  out  1  one-cycle pulse; results valid.
REQ-012 x_o, y_o, z_o  out  IO_WIDTH each  registered results.
REQ-013 err_o  out  1  vectoring with x=0; valid with done_o.
REQ-014 ovf_o  out  1  result saturated (see Configuration); valid with done_o.

Function
REQ-015 FSM states: IDLE, ITER, DONE; IDLE->ITER on start_i & ready_o; ITER->DONE after ITER_NUM iteration cycles; DONE->IDLE unconditionally.
REQ-016 start_i while not in IDLE is ignored; it is neither queued nor does it alter the operation in flight.
REQ-017 Iteration k (k = 0..ITER_NUM-1) uses shift k and constant 2^-k in z format (1<<(FRAC_BITS-k)); x is held constant throughout.
REQ-018 Vectoring: d = +1 if sign(y)==sign(x), else -1; y <= y - d*(x>>>k); z <= z + d*2^-k.
REQ-019 Rotation: d = +1 if z >= 0, else -1; y <= y + d*(x>>>k); z <= z - d*2^-k.
REQ-020 Shifts are arithmetic on sign-extended IO_WIDTH+GUARD_BITS values; no rounding.
REQ-021 Latency: done_o is high exactly ITER_NUM+1 cycles after the accepting edge; ready_o returns high the cycle after done_o.
REQ-022 x_o = latched x_i; y_o, z_o = final internal values reduced to IO_WIDTH; outputs, err_o and ovf_o update only on the DONE entry edge and hold until the next DONE.
REQ-023 Vectoring with x_i=0: iterations still run (fixed latency), err_o=1, z_o forced to z_i, y_o = y_i.
REQ-024 Back-to-back: start_i held high is re-accepted on the first IDLE cycle; throughput is one operation per ITER_NUM+2 cycles.

Reset
REQ-025 reset_n_i=0 at an edge forces IDLE, ready_o=1 on the following cycle, done_o=0, x_o=y_o=z_o=0, err_o=0, ovf_o=0, internal registers 0.
REQ-026 Reset mid-operation aborts it: no done_o pulse, outputs cleared to 0.
REQ-027 Reset has priority over start_i at the same edge.

Configuration
REQ-028 Macro CORDIC_LIN_SAT_EN defined: y_o and z_o saturate to [-2^(IO_WIDTH-1), 2^(IO_WIDTH-1)-1] when the internal value exceeds it, and ovf_o=1 for that result.
REQ-029 CORDIC_LIN_SAT_EN undefined: y_o and z_o take the low IO_WIDTH bits (wrap), and ovf_o is tied to 0.

Structure
REQ-030 Package cordic_lin_pkg holds the state enum, the mode enum (VECT=0, ROT=1), and the internal-width function (IO_WIDTH+GUARD_BITS).
REQ-031 Sub-module cordic_lin_step implements one combinational micro-rotation (inputs x, y, z, k, mode; outputs y', z'); the top instantiates it once and iterates it over time.

Verification (IO_WIDTH=18, FRAC_BITS=15, ITER_NUM=16; 1.0 = 32768)
REQ-032 Vectoring: x=16384, y=8192, z=0 -> z_o=16384 +/-2 LSB, |y_o|<=2, done_o at accept+17, err_o=0.
REQ-033 Rotation: x=16384, y=8192, z=16384 -> y_o=16384 +/-2 LSB, x_o=16384.
REQ-034 Vectoring: x=0, y=1000, z=5 -> err_o=1, z_o=5, y_o=1000, done_o at accept+17.
REQ-035 start_i pulsed at accept+3 and accept+10 -> ignored; exactly one done_o; ready_o=0 for 17 cycles after accept.
REQ-036 reset_n_i low at accept+8 -> no done_o, all outputs 0, ready_o=1 on the next cycle; a new start completes normally.
REQ-037 Rotation: x=114688, y=114688, z=62000 -> with CORDIC_LIN_SAT_EN, y_o=131071 and ovf_o=1; without it, y_o equals the low 18 bits of the internal value and ovf_o=0.
